alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Parametrised successor of the switch/button-driven ALU front end. Three raw push-buttons are synchronised, debounced and edge-detected. A state machine then enforces the operand load order A, B, Op. The operation is executed in a registered datapath that produces the result W, status flags and a one-cycle valid strobe. The block sits at the top of the board design, between the switches/buttons and the LEDs.

Parameters:
DATA_W, 8, operand/result width (>= OP_W, >= 4)
OP_W, 6, opcode width; Op is taken from switch[OP_W-1:0]
DEB_CYCLES, 500000, consecutive stable cycles required to accept a button level (10 ms at 50 MHz); bench uses 4

Ports:
mclk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
switch  in  DATA_W  operand/opcode source
b1  in  1  raw button: load A (asynchronous to mclk, bouncy)
b2  in  1  raw button: load B
b3  in  1  raw button: load Op
W  out  DATA_W  registered result
zero  out  1  W == 0
negative  out  1  W[DATA_W-1]
carry  out  1  ADD carry-out / SUB borrow
overflow  out  1  signed overflow for ADD/SUB
op_err  out  1  last executed Op is not a defined code
result_valid  out  1  one-cycle pulse when W/flags update
state  out  3  FSM state encoding, for LEDs

Behaviour:
- Reset (async, any state, including mid-debounce or EXEC): A=B=Op=0, W=0, all flags 0, result_valid=0, state=WAIT_A, debounce counters 0, edge detectors disarmed.
- Button conditioning, per button:
  - 2-flop synchroniser.
  - Counter counts consecutive cycles in which the synchronised level differs from the accepted level; it resets to 0 on any return to the accepted level.
  - When the counter reaches DEB_CYCLES, the accepted level flips.
  - A low-to-high flip of the accepted level produces exactly one 1-cycle pulse p1/p2/p3.
  - Latency from raw rising edge (stable) to pulse: 2 + DEB_CYCLES cycles.
- Opcodes (MIPS funct): ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, NOR 6'h27, SRL 6'h02, SRA 6'h03.
- FSM states: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SHOW=4.
  - p1 in any state except EXEC: A<=switch, goto WAIT_B. In EXEC, p1 is held one cycle and applied in SHOW.
  - p2 only in WAIT_B: B<=switch, goto WAIT_OP. Ignored elsewhere.
  - p3 in WAIT_OP or SHOW: Op<=switch[OP_W-1:0], goto EXEC. Ignored elsewhere.
  - Simultaneous pulses: priority p1 > p2 > p3; lower-priority pulses in the same cycle are dropped.
  - EXEC lasts exactly 1 cycle: W and flags register at its closing edge, result_valid=1 for the following cycle, goto SHOW.
  - SHOW: W and flags hold until the next EXEC or reset. They are never cleared by p1.
- Arithmetic, all unsigned DATA_W-bit with wrap-around:
  - ADD: carry = bit DATA_W of A+B; overflow = operands same sign and result sign differs.
  - SUB: W=A-B; carry=1 iff A<B unsigned; overflow per signed subtraction.
  - Logic ops: carry=overflow=0.
  - SRL/SRA: shift A right by B (full B value). B >= DATA_W gives all-0 (SRL) or all-A[MSB] (SRA).
  - Undefined Op: W=0, op_err=1, carry=overflow=0.
  - zero and negative are always derived from the new W.

Decomposition:
- Shared package alu_pkg: opcode localparams, FSM state encodings, shift-amount width function (clog2 DATA_W).
- One sub-module, button_conditioner (params DEB_CYCLES), instanced 3 times. It contains the synchroniser, debounce counter and rising-edge pulse.
- Datapath and FSM stay in alu_sequencer.

Test Plan:
- Reset mid-sequence: load A, assert rst while b2 is being debounced -> state=0, W=0, all flags 0, a subsequent b2 press ignored.
- A=8'h7F, B=8'h01, Op=6'h20 -> W=8'h80, overflow=1, negative=1, carry=0, zero=0, result_valid high exactly 1 cycle, state=4.
- Then press b3 again with Op=6'h22 (SHOW re-exec) -> W=8'h7E, carry=0, overflow=0. Then A=8'h00, B=8'h01, SUB -> W=8'hFF, carry=1.
- Bounce, DEB_CYCLES=4: b1 high 3 cycles, low, high 3 cycles -> no load, state=0. b1 high 6 cycles -> exactly one load, state=1.
- Ordering: b3 then b2 in WAIT_A -> no register change, state=0. b1+b2 in the same cycle in SHOW -> only A loaded, state=1.
- Shifts and errors:
  - A=8'h80, B=3, SRA -> 8'hF0.
  - B=9, SRA -> 8'hFF.
  - B=9, SRL -> 8'h00, zero=1.
  - Op=6'h3F -> W=0, op_err=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode codes, FSM state encodings and sizing helper for the ALU sequencer.
package alu_pkg;

   localparam int unsigned OPC_W = 6;

   localparam logic [OPC_W-1:0] OP_ADD = 6'h20;
   localparam logic [OPC_W-1:0] OP_SUB = 6'h22;
   localparam logic [OPC_W-1:0] OP_AND = 6'h24;
   localparam logic [OPC_W-1:0] OP_OR  = 6'h25;
   localparam logic [OPC_W-1:0] OP_XOR = 6'h26;
   localparam logic [OPC_W-1:0] OP_NOR = 6'h27;
   localparam logic [OPC_W-1:0] OP_SRL = 6'h02;
   localparam logic [OPC_W-1:0] OP_SRA = 6'h03;

   typedef enum logic [2:0] {
      ST_WAIT_A  = 3'd0,
      ST_WAIT_B  = 3'd1,
      ST_WAIT_OP = 3'd2,
      ST_EXEC    = 3'd3,
      ST_SHOW    = 3'd4
   } state_e;

   // Bits needed to express an in-range shift amount for a w-bit operand.
   function automatic int unsigned shamt_w(input int unsigned w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button to single-cycle press pulse: 2-flop synchroniser,
// consecutive-cycle debounce counter and rising-edge detector on the accepted level.
module button_conditioner #(
   parameter int unsigned DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic pulse_o
);

   localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter only advances while the synchronised level disagrees with the accepted one.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      pulse_d = level_d & ~level_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_sequencer.sv
// Button-driven ALU front end: loads A, B, Op in order from the switches and
// executes in a registered datapath with status flags and a result strobe.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned OP_W       = 6,
   parameter int unsigned DEB_CYCLES = 500000
) (
   input  logic              mclk,
   input  logic              rst,
   input  logic [DATA_W-1:0] switch,
   input  logic              b1,
   input  logic              b2,
   input  logic              b3,
   output logic [DATA_W-1:0] W,
   output logic              zero,
   output logic              negative,
   output logic              carry,
   output logic              overflow,
   output logic              op_err,
   output logic              result_valid,
   output logic [2:0]        state
);

   localparam int unsigned SH_W = shamt_w(DATA_W);

   logic p1, p2, p3, p1_eff;

   button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn1 (.clk(mclk), .rst(rst), .btn_i(b1), .pulse_o(p1));
   button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn2 (.clk(mclk), .rst(rst), .btn_i(b2), .pulse_o(p2));
   button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn3 (.clk(mclk), .rst(rst), .btn_i(b3), .pulse_o(p3));

   state_e            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              hold_q, hold_d;
   logic              valid_q, valid_d;
   logic              res_load;

   logic [DATA_W-1:0] w_q, res_w;
   logic              zero_q, neg_q, carry_q, ovf_q, err_q;
   logic              res_c, res_v, res_e;

   // A p1 arriving during EXEC is parked in hold_q and replayed in SHOW.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      hold_d   = 1'b0;
      valid_d  = 1'b0;
      res_load = 1'b0;
      p1_eff   = p1 | hold_q;
      case (state_q)
         ST_EXEC: begin
            res_load = 1'b1;
            valid_d  = 1'b1;
            hold_d   = p1;
            state_d  = ST_SHOW;
         end
         ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP, ST_SHOW: begin
            if (p1_eff) begin
               a_d     = switch;
               state_d = ST_WAIT_B;
            end else if (p2 && state_q == ST_WAIT_B) begin
               b_d     = switch;
               state_d = ST_WAIT_OP;
            end else if (p3 && (state_q == ST_WAIT_OP || state_q == ST_SHOW)) begin
               op_d    = switch[OP_W-1:0];
               state_d = ST_EXEC;
            end
         end
         default: state_d = ST_WAIT_A;
      endcase
   end

   logic [DATA_W:0]   sum, diff;
   logic              shift_big;
   logic [SH_W-1:0]   sh;

   always_comb begin
      sum       = {1'b0, a_q} + {1'b0, b_q};
      diff      = {1'b0, a_q} - {1'b0, b_q};
      shift_big = (b_q > DATA_W'(DATA_W - 1));
      sh        = b_q[SH_W-1:0];
      res_w     = '0;
      res_c     = 1'b0;
      res_v     = 1'b0;
      res_e     = 1'b0;
      case (op_q)
         OP_W'(OP_ADD): begin
            res_w = sum[DATA_W-1:0];
            res_c = sum[DATA_W];
            res_v = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
         end
         OP_W'(OP_SUB): begin
            res_w = diff[DATA_W-1:0];
            res_c = diff[DATA_W];
            res_v = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
         end
         OP_W'(OP_AND): res_w = a_q & b_q;
         OP_W'(OP_OR):  res_w = a_q | b_q;
         OP_W'(OP_XOR): res_w = a_q ^ b_q;
         OP_W'(OP_NOR): res_w = ~(a_q | b_q);
         OP_W'(OP_SRL): res_w = shift_big ? '0 : (a_q >> sh);
         OP_W'(OP_SRA): res_w = shift_big ? {DATA_W{a_q[DATA_W-1]}}
                                          : DATA_W'($signed(a_q) >>> sh);
         default:       res_e = 1'b1;
      endcase
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         state_q <= ST_WAIT_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         hold_q  <= 1'b0;
         valid_q <= 1'b0;
         w_q     <= '0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
         if (res_load) begin
            w_q     <= res_w;
            zero_q  <= (res_w == '0);
            neg_q   <= res_w[DATA_W-1];
            carry_q <= res_c;
            ovf_q   <= res_v;
            err_q   <= res_e;
         end
      end
   end

   assign W            = w_q;
   assign zero         = zero_q;
   assign negative     = neg_q;
   assign carry        = carry_q;
   assign overflow     = ovf_q;
   assign op_err       = err_q;
   assign result_valid = valid_q;
   assign state        = state_q;

endmodule
